uart_tx_driver: RTL
===================

Name: uart_tx_driver

Overview:
Testbench-side UART transmitter that serialises bytes into the DUT's uart_rx_i pin. It is the stimulus counterpart of the UART monitor that decodes uart_tx_o. A bench process pushes bytes through a valid/ready port into an internal FIFO. The block emits 8N1/8E1/8O1/8x2 frames at a runtime-programmable bit period.

Parameters:
FIFO_DEPTH, 16, byte FIFO entries; power of two, at least 2.
DIV_W, 16, width of bit_period_i.

Ports:
clk_i  input  1  clock; all logic on the rising edge.
rst_i  input  1  synchronous, active-high reset.
enable_i  input  1  permits starting new frames.
parity_enable_i  input  1  inserts a parity bit after the data bits.
parity_odd_i  input  1  1 = odd parity, 0 = even parity.
two_stop_i  input  1  1 = two stop bits, 0 = one stop bit.
bit_period_i  input  DIV_W  clk_i cycles per UART bit.
wdata_i  input  8  byte to transmit.
wvalid_i  input  1  push request.
wready_o  output  1  FIFO can accept a byte.
tx_o  output  1  serial line; idles high; drives DUT uart_rx_i.
busy_o  output  1  a frame is in progress.
fifo_level_o  output  $clog2(FIFO_DEPTH)+1  number of queued bytes.
done_o  output  1  one-cycle pulse at the end of each frame.

Behaviour:
- Reset (rst_i high at a rising edge): on the next cycle tx_o=1, wready_o=1, busy_o=0, fifo_level_o=0, done_o=0, FSM=IDLE.
  - The FIFO is flushed and any in-flight frame is abandoned with no partial bits.
  - Applies identically when reset hits mid-frame.
- FIFO:
  - A push occurs when wvalid_i && wready_o.
  - wready_o = (level != FIFO_DEPTH); it is registered from level and does not depend on the same-cycle pop.
  - Push and pop in the same cycle leave the level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Bit period:
  - eff_period = max(bit_period_i, 4).
  - Latched into an internal register when a frame starts; changes mid-frame have no effect until the next frame.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if enable_i && level>0, pop the head byte, latch the config inputs (parity_enable_i, parity_odd_i, two_stop_i, eff_period) and go to START. tx_o goes low on the cycle after the pop decision (1-cycle latency), and busy_o goes high on that same cycle.
  - START: tx_o=0 for exactly eff_period cycles, then DATA.
  - DATA: 8 bits, LSB first, each held exactly eff_period cycles. A 3-bit index counts 0..7. After bit 7: PARITY if parity is enabled, else STOP.
  - PARITY: tx_o = ^data XOR parity_odd (even: total ones including the parity bit is even). Held eff_period cycles, then STOP.
  - STOP: tx_o=1 for eff_period cycles, or 2*eff_period if two_stop. On the final cycle of the stop period, done_o=1 for exactly that cycle.
    - If enable_i && level>0 on that cycle, pop and go directly to START: the next start bit follows with no idle gap and busy_o stays 1.
    - Otherwise go to IDLE, with busy_o=0 from the next cycle.
- Bit-cycle counter: a DIV_W-bit down-counter loaded with eff_period-1 at each bit start; the bit advances when it reaches 0.
- Frame length: (10 + parity_enable + two_stop) * eff_period cycles.
- enable_i deasserted mid-frame: the current frame completes normally, then no new frame starts. Queued bytes remain.
- tx_o, busy_o and done_o are registered outputs with no combinational path from any input.
- Parity and stop settings are latched per frame, so configuration changes only affect subsequent frames.

Test Plan:
- Single frame, 8N1: bit_period=16, push 0x55, enable=1.
  - tx_o falls 1 cycle after the push-visible cycle; start bit lasts 16 cycles.
  - Data line pattern is 1,0,1,0,1,0,1,0; then 16 stop cycles.
  - done_o pulses at cycle 160 of the frame, then busy_o=0.
- Parity: 0x07 with even parity gives parity bit 1; 0x07 with odd parity gives 0; 0x00 with even parity gives 0.
  - Frame length is 176 cycles at period 16.
- FIFO full: enable=0, push 16 bytes.
  - fifo_level_o=16 and wready_o=0; a 17th wvalid is not accepted.
  - Set enable=1: bytes emerge in push order, back-to-back with no idle cycles between the stop and the next start.
- Two stop bits: push 0xA3 and 0x3C with two_stop=1, period 8.
  - Each frame is 88 cycles; tx_o stays high for 16 cycles between frames.
  - The monitor decodes 0xA3 then 0x3C.
- Clamping and latching:
  - bit_period=2 gives 4-cycle bits.
  - Changing bit_period from 8 to 12 mid-frame keeps 8 for the current frame and uses 12 for the next.
- Reset mid-frame: assert rst_i during DATA bit 3 with 5 bytes queued.
  - The next cycle shows tx_o=1, busy_o=0, fifo_level_o=0 and no done_o pulse.
  - A subsequent push transmits correctly.

Source files
------------

// File: rtl/uart_tx_driver.sv
// uart_tx_driver: bench-side UART transmitter. Bytes are queued through a
// valid/ready port into a small FIFO and sent as 8-bit frames with optional
// even/odd parity and one or two stop bits. The bit period is set at runtime.
module uart_tx_driver #(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          enable_i,
    input  logic                          parity_enable_i,
    input  logic                          parity_odd_i,
    input  logic                          two_stop_i,
    input  logic [DIV_W-1:0]              bit_period_i,
    input  logic [7:0]                    wdata_i,
    input  logic                          wvalid_i,
    output logic                          wready_o,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          done_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Bits shorter than 4 cycles are stretched to 4.
    function automatic logic [DIV_W-1:0] clamp_period(input logic [DIV_W-1:0] p);
        return (p < DIV_W'(4)) ? DIV_W'(4) : p;
    endfunction

    // Even parity makes the total count of ones even; odd flips it.
    function automatic logic parity_bit(input logic [7:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    // FIFO storage and control
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [7:0]       mem_d [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             wready_q, wready_d;

    // Frame state
    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic             stop_more_q, stop_more_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Per-frame latched data and configuration
    logic [7:0]       data_q, data_d;
    logic [DIV_W-1:0] per_q, per_d;
    logic             par_en_q, par_en_d;
    logic             par_odd_q, par_odd_d;
    logic             two_stop_q, two_stop_d;

    logic             push;
    logic             pop;
    logic             start_now;
    logic             can_start;
    logic             cnt_last;
    logic [DIV_W-1:0] eff_period;

    assign push       = wvalid_i && wready_q;
    assign can_start  = enable_i && (level_q != '0);
    assign cnt_last   = (cnt_q == '0);
    assign eff_period = clamp_period(bit_period_i);

    // FIFO next state: write on push, advance read on pop, track level.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            mem_d[wr_ptr_q] = wdata_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        wready_d = (level_d != LW'(FIFO_DEPTH));
    end

    // Frame sequencer: next state, bit counter and registered line outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        stop_more_d = stop_more_q;
        tx_d        = tx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        data_d      = data_q;
        per_d       = per_q;
        par_en_d    = par_en_q;
        par_odd_d   = par_odd_q;
        two_stop_d  = two_stop_q;
        pop         = 1'b0;
        start_now   = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (can_start) begin
                    start_now = 1'b1;
                end
            end
            S_START: begin
                if (cnt_last) begin
                    state_d = S_DATA;
                    idx_d   = 3'd0;
                    tx_d    = data_q[0];
                    cnt_d   = per_q - 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_last) begin
                    cnt_d = per_q - 1'b1;
                    if (idx_q == 3'd7) begin
                        if (par_en_q) begin
                            state_d = S_PARITY;
                            tx_d    = parity_bit(data_q, par_odd_q);
                        end else begin
                            state_d     = S_STOP;
                            tx_d        = 1'b1;
                            stop_more_d = two_stop_q;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                        tx_d  = data_q[idx_q + 3'd1];
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_PARITY: begin
                if (cnt_last) begin
                    state_d     = S_STOP;
                    tx_d        = 1'b1;
                    stop_more_d = two_stop_q;
                    cnt_d       = per_q - 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_STOP: begin
                // done is registered, so raise it one cycle before the last stop cycle.
                done_d = !stop_more_q && (cnt_q == DIV_W'(1));
                if (cnt_last) begin
                    if (stop_more_q) begin
                        stop_more_d = 1'b0;
                        cnt_d       = per_q - 1'b1;
                    end else if (can_start) begin
                        start_now = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        // Popping the head byte also latches the frame configuration.
        if (start_now) begin
            pop         = 1'b1;
            data_d      = mem_q[rd_ptr_q];
            per_d       = eff_period;
            par_en_d    = parity_enable_i;
            par_odd_d   = parity_odd_i;
            two_stop_d  = two_stop_i;
            cnt_d       = eff_period - 1'b1;
            stop_more_d = 1'b0;
            state_d     = S_START;
            tx_d        = 1'b0;
            busy_d      = 1'b1;
        end
    end

    // Control registers with synchronous reset; reset drops any partial frame.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            stop_more_q <= 1'b0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            wready_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            stop_more_q <= stop_more_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            wready_q    <= wready_d;
        end
    end

    // Data-path registers: FIFO contents and latched frame byte/config.
    always_ff @(posedge clk_i) begin
        mem_q      <= mem_d;
        data_q     <= data_d;
        per_q      <= per_d;
        par_en_q   <= par_en_d;
        par_odd_q  <= par_odd_d;
        two_stop_q <= two_stop_d;
    end

    assign wready_o     = wready_q;
    assign tx_o         = tx_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign fifo_level_o = level_q;

endmodule
